// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/ifu_pc_sel.sv
// ifu_pc_sel: next-PC mux for the fetch unit (hold / pc+4 / redirect).
// Optional macro IFU_MISALIGN_CHECK_EN: misaligned redirects are flagged and
// not applied; otherwise the low two redirect bits are forced to zero.
import ifu_pkg::*;

module ifu_pc_sel #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] pc_next
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    // Redirect has priority over sequential advance; otherwise PC holds.
    always_comb begin
        pc_next = pc;
`ifdef IFU_MISALIGN_CHECK_EN
        misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            if (!misaligned) begin
                pc_next = redirect_pc;
            end
        end else if (advance) begin
            pc_next = pc + XLEN'(PC_STEP);
        end
`else
        if (redirect_valid) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end else if (advance) begin
            pc_next = pc + XLEN'(PC_STEP);
        end
`endif
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Holds the PC, issues one outstanding
// word fetch at a time and presents returned instructions to decode.
// Optional macro IFU_MISALIGN_CHECK_EN: adds the fetch_misaligned port and a
// sticky FAULT state entered on a misaligned redirect.
import ifu_pkg::*;

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            kill;
    logic            redirect_en;
    logic            advance;
`ifdef IFU_MISALIGN_CHECK_EN
    logic            misaligned;
`endif

    assign redirect_en = redirect_valid && (state != FAULT);
    assign advance     = (state == HOLD) && inst_ready;

    ifu_pc_sel #(
        .XLEN(XLEN)
    ) u_pc_sel (
        .pc            (pc),
        .advance       (advance),
        .redirect_valid(redirect_en),
        .redirect_pc   (redirect_pc),
`ifdef IFU_MISALIGN_CHECK_EN
        .misaligned    (misaligned),
`endif
        .pc_next       (pc_next)
    );

    // Fetch FSM with registered request/instruction outputs; the request
    // address tracks the PC register so a redirect before the handshake
    // shows up on the bus the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            inst_valid     <= 1'b0;
            inst           <= INST_NOP;
            inst_pc        <= RESET_PC;
`ifdef IFU_MISALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            pc            <= pc_next;
            imem_req_addr <= pc_next;
            unique case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        kill           <= redirect_en;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill || redirect_en) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            kill           <= 1'b0;
                        end else begin
                            state      <= HOLD;
                            inst_valid <= 1'b1;
                            inst       <= imem_resp_data;
                            inst_pc    <= pc;
                        end
                    end else if (redirect_en) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_en || inst_ready) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        inst_valid     <= 1'b0;
                    end
                end
                FAULT: begin
                end
            endcase
`ifdef IFU_MISALIGN_CHECK_EN
            if (misaligned) begin
                state            <= FAULT;
                imem_req_valid   <= 1'b0;
                inst_valid       <= 1'b0;
                inst_pc          <= redirect_pc;
                kill             <= 1'b0;
                fetch_misaligned <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios plus randomized traffic for ifu_fetch,
// checked against a program-order PC model and a memory image function.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    ifu_fetch #(
        .RESET_PC(32'h8000_0000),
        .XLEN    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // reference model state
    logic [31:0] exp_pc;
    bit          pend;
    int unsigned pend_at;
    logic [31:0] pend_addr;
    int unsigned cyc;
    int unsigned lat;
    bit          spur;
    int unsigned delivered;
    bit          prev_req_stall;
    bit          prev_inst_stall;
    bit          prev_hold_redir;
    logic [31:0] prev_addr;
    logic [31:0] prev_inst;
    logic [31:0] prev_ipc;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // program image held by the instruction memory
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return {a[15:0], a[31:16]} ^ 32'h5A3C_0F93;
    endfunction

    task automatic reset_dut();
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst             = 1'b0;
        exp_pc          = 32'h8000_0000;
        pend            = 1'b0;
        cyc             = 0;
        spur            = 1'b0;
        prev_req_stall  = 1'b0;
        prev_inst_stall = 1'b0;
        prev_hold_redir = 1'b0;
    endtask

    // One cycle: memory responds, outputs are checked against the model,
    // the model advances, then the clock edge happens.
    task automatic tick();
        bit consumed;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend && cyc == pend_at) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr);
            pend            = 1'b0;
        end else if (spur && !pend && !imem_req_valid) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = $urandom;
        end
        if (prev_req_stall)
            check("req_stable", {imem_req_valid, imem_req_addr}, {1'b1, prev_addr});
        if (prev_inst_stall)
            check("inst_stable", {inst_valid, inst, inst_pc}, {1'b1, prev_inst, prev_ipc});
        if (prev_hold_redir)
            check("redir_drop", inst_valid, 1'b0);
        if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", pend, 1'b0);
            check("req_addr", imem_req_addr, exp_pc);
            pend      = 1'b1;
            pend_at   = cyc + lat;
            pend_addr = imem_req_addr;
        end
        if (inst_valid) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst, mem_word(inst_pc));
        end
        consumed        = inst_valid && inst_ready;
        if (consumed) delivered++;
        prev_req_stall  = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_inst_stall = inst_valid && !inst_ready && !redirect_valid;
        prev_hold_redir = inst_valid && redirect_valid;
        prev_addr       = imem_req_addr;
        prev_inst       = inst;
        prev_ipc        = inst_pc;
        if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        else if (consumed) exp_pc = exp_pc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
        spur           = 1'b0;
    endtask

    task automatic wait_for(input bit for_req, input int unsigned max_cyc, input string tag);
        int unsigned n = 0;
        while (!(for_req ? imem_req_valid : inst_valid) && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, for_req ? imem_req_valid : inst_valid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        delivered = 0;
        lat       = 1;
        reset_dut();

        // reset state, best-case latency
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        check("rst_inst", {inst_valid, inst, inst_pc}, {1'b0, 32'h0000_0013, 32'h8000_0000});
`ifdef IFU_MISALIGN_CHECK_EN
        check("rst_fault", fetch_misaligned, 1'b0);
`endif
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        spur           = 1'b1;
        tick();
        check("lat_req_c1", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0000});
        tick();
        check("lat_wait_c2", inst_valid, 1'b0);
        tick();
        check("lat_inst_c3", {inst_valid, inst, inst_pc}, {1'b1, 32'h0010_0093, 32'h8000_0000});
        tick();
        check("next_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0004});

        // request stall with a redirect in the middle
        imem_req_ready = 1'b0;
        tick();
        check("stall_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0004});
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        check("stall_redir_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0200});
        tick();
        imem_req_ready = 1'b1;
        lat            = 3;
        check("accepted_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0200});
        tick();

        // redirect while waiting: stale response must be dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        n = 0;
        while (!imem_req_valid && n < 10) begin
            check("stale_drop", inst_valid, 1'b0);
            tick();
            n++;
        end
        check("kill_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0100});

        // decode stall, then redirect together with inst_ready
        lat        = 1;
        inst_ready = 1'b0;
        tick();
        wait_for(1'b0, 10, "hold_arrive");
        repeat (5) tick();
        check("hold_stable", {inst_valid, inst, inst_pc},
              {1'b1, mem_word(32'h8000_0100), 32'h8000_0100});
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        inst_ready     = 1'b1;
        tick();
        check("redir_ready_drop", inst_valid, 1'b0);
        wait_for(1'b1, 10, "redir_req");
        check("redir_not_inc", imem_req_addr, 32'h8000_0300);

        // PC wrap past the top of the address space
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        imem_req_ready = 1'b1;
        lat            = 2;
        check("wrap_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFFC});
        tick();
        wait_for(1'b0, 10, "wrap_inst");
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        wait_for(1'b1, 10, "wrap_next_req");
        check("wrap_addr", imem_req_addr, 32'h0000_0000);

        // misaligned redirect
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
`ifdef IFU_MISALIGN_CHECK_EN
        check("misalign_flag", fetch_misaligned, 1'b1);
        check("misalign_pc", inst_pc, 32'h8000_0102);
        imem_req_ready = 1'b1;
        repeat (5) begin
            check("fault_quiet", {imem_req_valid, inst_valid, fetch_misaligned}, 3'b001);
            tick();
        end
`else
        check("misalign_forced", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0100});
        imem_req_ready = 1'b1;
        tick();
`endif

        // randomized traffic
        reset_dut();
        delivered = 0;
        for (int unsigned i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            lat            = $urandom_range(1, 3);
            spur           = ($urandom % 6) == 0;
            if (($urandom % 9) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom % 4)
                    0:       redirect_pc = 32'hFFFF_FFF0 + ($urandom % 4) * 4;
                    1:       redirect_pc = 32'h8000_0000 + ($urandom % 64) * 4;
                    default: redirect_pc = $urandom;
                endcase
`ifdef IFU_MISALIGN_CHECK_EN
                redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            end
            tick();
        end
        check("progress", delivered >= 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
